// File: rtl/i2c_pkg.sv
// Shared types for the I2C target: FSM states, bus-condition codes and the R/W bit meaning.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK
    } i2c_slv_state_t;

    typedef enum logic [1:0] {
        COND_NONE,
        COND_START,
        COND_STOP
    } i2c_cond_t;

    localparam logic I2C_RW_READ = 1'b1;

    // SDA may only move while SCL is high to signal START (falling) or STOP (rising).
    function automatic i2c_cond_t bus_cond(input logic scl_level, input logic sda_rise,
                                           input logic sda_fall);
        if (scl_level && sda_fall) return COND_START;
        if (scl_level && sda_rise) return COND_STOP;
        return COND_NONE;
    endfunction

endpackage

// File: rtl/i2c_pin_filter.sv
// Two-flop synchronizer plus a hold-time glitch filter for one I2C pin, with edge pulses
// that are high in the same cycle the filtered level changes.
module i2c_pin_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic core_clk,
    input  logic preset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // The filtered level flips only after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge core_clk) begin
        if (preset) begin
            sync  <= 2'b11;
            level <= 1'b1;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], pin};
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                level <= sync[1];
                cnt   <= '0;
                rise  <= sync[1];
                fall  <= ~sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target holding a byte register file: pointer-then-data writes, auto-incrementing reads,
// a combinational host read port and a write-event strobe.
module i2c_slave_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         DEPTH      = 8,
    parameter int         FILTER_LEN = 3
) (
    input  logic                     core_clk,
    input  logic                     preset,
    input  logic                     scl_in,
    input  logic                     sda_in,
    output logic                     sda_oe,
    input  logic [$clog2(DEPTH)-1:0] host_raddr,
    output logic [7:0]               host_rdata,
    output logic                     wr_valid,
    output logic [$clog2(DEPTH)-1:0] wr_index,
    output logic [7:0]               wr_data,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_pin_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .core_clk(core_clk), .preset(preset), .pin(scl_in),
        .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_pin_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .core_clk(core_clk), .preset(preset), .pin(sda_in),
        .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
    );

    i2c_slv_state_t state, state_n;
    logic [3:0]     bit_cnt, bit_cnt_n;
    logic [6:0]     shift, shift_n;
    logic [AW-1:0]  ptr, ptr_n;
    logic           sda_oe_n, busy_n, rw, rw_n;
    logic           wr_valid_n, reg_we;
    logic [AW-1:0]  wr_index_n;
    logic [7:0]     wr_data_n;
    logic [7:0]     byte_in, rd_byte;
    i2c_cond_t      cond;
    logic [7:0]     regs [DEPTH];

    assign host_rdata = regs[host_raddr];
    assign rd_byte    = regs[ptr];
    assign byte_in    = {shift, sda_lvl};
    assign cond       = bus_cond(scl_lvl, sda_rise, sda_fall);

    always_ff @(posedge core_clk) begin
        if (preset) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            ptr      <= '0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            rw       <= 1'b0;
            wr_valid <= 1'b0;
            wr_index <= '0;
            wr_data  <= '0;
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            shift    <= shift_n;
            ptr      <= ptr_n;
            sda_oe   <= sda_oe_n;
            busy     <= busy_n;
            rw       <= rw_n;
            wr_valid <= wr_valid_n;
            wr_index <= wr_index_n;
            wr_data  <= wr_data_n;
            if (reg_we) regs[ptr] <= wr_data_n;
        end
    end

    // START/STOP override every state; all SDA drive changes follow a filtered SCL fall.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        ptr_n      = ptr;
        sda_oe_n   = sda_oe;
        busy_n     = busy;
        rw_n       = rw;
        wr_valid_n = 1'b0;
        wr_index_n = wr_index;
        wr_data_n  = wr_data;
        reg_we     = 1'b0;

        if (cond == COND_STOP) begin
            state_n  = IDLE;
            busy_n   = 1'b0;
            sda_oe_n = 1'b0;
        end else if (cond == COND_START) begin
            state_n   = ADDR;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        shift_n   = byte_in[6:0];
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_n = '0;
                            if (byte_in[7:1] == SLAVE_ADDR) begin
                                state_n = ADDR_ACK;
                                busy_n  = 1'b1;
                                rw_n    = byte_in[0];
                            end else begin
                                state_n = IDLE;
                            end
                        end
                    end
                end
                // First fall after the byte pulls SDA low, the second ends the ACK slot.
                ADDR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_n = 1'b1;
                        end else if (state == ADDR_ACK && rw == I2C_RW_READ) begin
                            state_n   = RD_BYTE;
                            sda_oe_n  = ~rd_byte[7];
                            bit_cnt_n = 4'd1;
                        end else begin
                            state_n   = (state == ADDR_ACK) ? PTR : WR_BYTE;
                            sda_oe_n  = 1'b0;
                            bit_cnt_n = '0;
                        end
                    end
                end
                PTR, WR_BYTE: begin
                    if (scl_rise) begin
                        shift_n   = byte_in[6:0];
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_n = '0;
                            state_n   = WR_ACK;
                            if (state == PTR) begin
                                ptr_n = byte_in[AW-1:0];
                            end else begin
                                reg_we     = 1'b1;
                                wr_valid_n = 1'b1;
                                wr_index_n = ptr;
                                wr_data_n  = byte_in;
                                ptr_n      = ptr + 1'b1;
                            end
                        end
                    end
                end
                RD_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt != 4'd8) begin
                            sda_oe_n  = ~rd_byte[3'd7 - bit_cnt[2:0]];
                            bit_cnt_n = bit_cnt + 4'd1;
                        end else begin
                            sda_oe_n  = 1'b0;
                            state_n   = RD_ACK;
                            bit_cnt_n = '0;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_lvl) begin
                            ptr_n   = ptr + 1'b1;
                            state_n = RD_BYTE;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Self-checking bench: open-drain I2C master BFM, register-file reference model and a
// scoreboard that matches every wr_valid strobe against the expected write queue.
module tb_i2c_slave_responder;

    localparam logic [6:0] SLAVE_ADDR = 7'h50;
    localparam int         DEPTH      = 8;
    localparam int         FILTER_LEN = 3;
    localparam int         AW         = $clog2(DEPTH);
    localparam int         Q          = 10;

    logic          core_clk = 1'b0;
    logic          preset   = 1'b1;
    logic          m_scl_low = 1'b0;
    logic          m_sda_low = 1'b0;
    logic          scl_bus, sda_bus;
    logic          sda_oe;
    logic [AW-1:0] host_raddr = '0;
    logic [7:0]    host_rdata;
    logic          wr_valid;
    logic [AW-1:0] wr_index;
    logic [7:0]    wr_data;
    logic          busy;

    assign scl_bus = ~m_scl_low;
    assign sda_bus = ~(m_sda_low | sda_oe);

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [7:0]    data;
    } wr_exp_t;

    wr_exp_t    exp_wr[$];
    logic [7:0] model[DEPTH];
    int         mptr = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    bit         quiet = 1'b0;
    int         quiet_viol = 0;
    logic [7:0] dq[$];

    i2c_slave_responder #(
        .SLAVE_ADDR(SLAVE_ADDR), .DEPTH(DEPTH), .FILTER_LEN(FILTER_LEN)
    ) dut (
        .core_clk(core_clk), .preset(preset), .scl_in(scl_bus), .sda_in(sda_bus),
        .sda_oe(sda_oe), .host_raddr(host_raddr), .host_rdata(host_rdata),
        .wr_valid(wr_valid), .wr_index(wr_index), .wr_data(wr_data), .busy(busy)
    );

    always #5 core_clk = ~core_clk;

    initial begin
        #900_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expected write.
    always @(negedge core_clk) begin : wr_monitor
        wr_exp_t e;
        if (wr_valid) begin
            if (exp_wr.size() == 0) begin
                checkOutput("wr_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_wr.pop_front();
                checkOutput("wr_index", 32'(wr_index), 32'(e.idx));
                checkOutput("wr_data", 32'(wr_data), 32'(e.data));
            end
        end
    end

    always @(negedge core_clk) begin
        if (quiet && (sda_oe || wr_valid)) quiet_viol++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge core_clk);
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0; wait_cyc(Q);
        m_scl_low = 1'b0; wait_cyc(Q);
        m_sda_low = 1'b1; wait_cyc(Q);
        m_scl_low = 1'b1; wait_cyc(Q);
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1; wait_cyc(Q);
        m_scl_low = 1'b0; wait_cyc(Q);
        m_sda_low = 1'b0; wait_cyc(Q);
    endtask

    task automatic i2c_bit(input logic b, input logic glitch, output logic r);
        m_sda_low = ~b;
        if (glitch) begin
            wait_cyc(3);
            m_scl_low = 1'b0; wait_cyc(FILTER_LEN - 1);
            m_scl_low = 1'b1; wait_cyc(Q - 3 - (FILTER_LEN - 1));
        end else begin
            wait_cyc(Q);
        end
        m_scl_low = 1'b0; wait_cyc(Q);
        r = sda_bus;      wait_cyc(Q);
        m_scl_low = 1'b1; wait_cyc(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) i2c_bit(b[i], logic'(i == glitch_bit), r);
        i2c_bit(1'b1, 1'b0, r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic send_ack, output logic [7:0] rb);
        logic r;
        rb = '0;
        for (int i = 0; i < 8; i++) begin
            i2c_bit(1'b1, 1'b0, r);
            rb = {rb[6:0], r};
        end
        i2c_bit(~send_ack, 1'b0, r);
    endtask

    task automatic check_host();
        for (int i = 0; i < DEPTH; i++) begin
            host_raddr = AW'(i);
            #1;
            checkOutput($sformatf("host_rdata[%0d]", i), 32'(host_rdata), 32'(model[i]));
        end
    endtask

    // Write transaction: address, pointer byte, then the bytes queued in dq.
    task automatic applyStimulus(input logic [7:0] addr_byte, input logic [7:0] p,
                                 input int glitch_bit);
        logic match, ack;
        match = (addr_byte[7:1] == SLAVE_ADDR) && !addr_byte[0];
        quiet_viol = 0;
        quiet = ~match;
        i2c_start();
        write_byte(addr_byte, -1, ack);
        checkOutput("addr_ack", 32'(ack), 32'(match));
        write_byte(p, -1, ack);
        checkOutput("ptr_ack", 32'(ack), 32'(match));
        if (match) mptr = int'(p) % DEPTH;
        checkOutput("busy_mid", 32'(busy), 32'(match));
        foreach (dq[i]) begin
            if (match) begin
                exp_wr.push_back({AW'(mptr), dq[i]});
                model[mptr] = dq[i];
                mptr = (mptr + 1) % DEPTH;
            end
            write_byte(dq[i], (i == 0) ? glitch_bit : -1, ack);
            checkOutput("data_ack", 32'(ack), 32'(match));
        end
        i2c_stop();
        wait_cyc(Q);
        checkOutput("busy_after_stop", 32'(busy), 32'd0);
        quiet = 1'b0;
        if (!match) checkOutput("mismatch_quiet", 32'(quiet_viol), 32'd0);
        check_host();
    endtask

    task automatic read_txn(input logic set_ptr, input logic [7:0] p, input int n);
        logic ack;
        logic [7:0] rb;
        i2c_start();
        if (set_ptr) begin
            write_byte({SLAVE_ADDR, 1'b0}, -1, ack);
            checkOutput("rd_addr_w_ack", 32'(ack), 32'd1);
            write_byte(p, -1, ack);
            checkOutput("rd_ptr_ack", 32'(ack), 32'd1);
            mptr = int'(p) % DEPTH;
            i2c_start();
        end
        write_byte({SLAVE_ADDR, 1'b1}, -1, ack);
        checkOutput("rd_addr_r_ack", 32'(ack), 32'd1);
        for (int i = 0; i < n; i++) begin
            read_byte(logic'(i < n - 1), rb);
            checkOutput("rd_data", 32'(rb), 32'(model[mptr]));
            if (i < n - 1) mptr = (mptr + 1) % DEPTH;
        end
        wait_cyc(Q);
        checkOutput("rd_release", 32'(sda_oe), 32'd0);
        checkOutput("rd_busy_until_stop", 32'(busy), 32'd1);
        i2c_stop();
        wait_cyc(Q);
        checkOutput("rd_busy_after_stop", 32'(busy), 32'd0);
    endtask

    task automatic reset_model();
        foreach (model[i]) model[i] = 8'h00;
        mptr = 0;
    endtask

    initial begin
        logic ack;
        int   kind, n;
        logic [6:0] bad;
        reset_model();
        wait_cyc(5);
        checkOutput("reset_sda_oe", 32'(sda_oe), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_wr_valid", 32'(wr_valid), 32'd0);
        preset = 1'b0;
        wait_cyc(5);
        check_host();

        $display("[TB] T1 write");
        dq = {}; dq.push_back(8'h11); dq.push_back(8'h22);
        applyStimulus(8'hA0, 8'h02, -1);

        $display("[TB] T2 read with repeated START");
        read_txn(1'b1, 8'h02, 2);

        $display("[TB] T3 pointer wrap");
        dq = {}; dq.push_back(8'hAA); dq.push_back(8'hBB);
        applyStimulus(8'hA0, 8'h07, -1);

        $display("[TB] T4 address mismatch");
        dq = {}; dq.push_back(8'h55);
        applyStimulus(8'hB0, 8'h55, -100);

        $display("[TB] T5 SCL glitch and reset during read");
        dq = {}; dq.push_back(8'h5A);
        applyStimulus(8'hA0, 8'h04, 3);

        i2c_start();
        write_byte({SLAVE_ADDR, 1'b0}, -1, ack);
        checkOutput("t5_addr_ack", 32'(ack), 32'd1);
        write_byte(8'h05, -1, ack);
        checkOutput("t5_ptr_ack", 32'(ack), 32'd1);
        i2c_start();
        write_byte({SLAVE_ADDR, 1'b1}, -1, ack);
        checkOutput("t5_rd_ack", 32'(ack), 32'd1);
        for (int i = 0; i < 2 * Q; i++) begin
            if (sda_oe) break;
            wait_cyc(1);
        end
        checkOutput("t5_drive_before_reset", 32'(sda_oe), 32'd1);
        preset = 1'b1;
        wait_cyc(1);
        checkOutput("t5_reset_release", 32'(sda_oe), 32'd0);
        checkOutput("t5_reset_busy", 32'(busy), 32'd0);
        preset = 1'b0;
        m_sda_low = 1'b0;
        m_scl_low = 1'b0;
        reset_model();
        wait_cyc(2 * Q);
        check_host();
        read_txn(1'b0, 8'h00, 1);

        $display("[TB] randomized transactions");
        for (int t = 0; t < 10; t++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin
                    n = $urandom_range(0, 3);
                    dq = {};
                    for (int i = 0; i < n; i++) dq.push_back(8'($urandom));
                    applyStimulus(8'hA0, 8'($urandom), -1);
                end
                1: read_txn(1'b1, 8'($urandom), $urandom_range(1, 3));
                2: read_txn(1'b0, 8'h00, $urandom_range(1, 2));
                default: begin
                    bad = 7'($urandom_range(0, 127));
                    if (bad == SLAVE_ADDR) bad = bad + 7'd1;
                    dq = {}; dq.push_back(8'($urandom));
                    applyStimulus({bad, 1'b0}, 8'($urandom), -100);
                end
            endcase
        end

        wait_cyc(Q);
        checkOutput("scoreboard_drain", 32'(exp_wr.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
